pulse_peak_detector: RTL and testbench
======================================

# pulse_peak_detector

Consumer of shaped-filter output: scans the sample stream from a `vN_filter` for above-threshold pulses and extracts each pulse's peak amplitude and peak timestamp. Results are presented as single events on a valid/ready handshake to downstream readout. It sits after the filter stage and is the reading end of the generator→filter data path.

## Interface
- `SIZE_DATA`, default `SIZE_FILTER_DATA+4`: width of the input sample, signed two's complement.
- `SIZE_PEAK_TIME`, default 16: width of the timestamp counter and of `peak_time`.
- `MAX_WIDTH`, default 64: pulse length, in cycles above threshold, at which a pulse counts as pileup. Used only with the macro.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `input_data`  in  SIZE_DATA  filter sample, one per clock.
- `threshold`  in  SIZE_DATA  signed trigger level.
- `holdoff`  in  8  dead cycles after each pulse.
- `peak_ready`  in  1  downstream accepts the event.
- `peak_valid`  out  1  event held in the output register.
- `peak_amp`  out  SIZE_DATA  maximum sample of the pulse.
- `peak_time`  out  SIZE_PEAK_TIME  timestamp of the first maximum sample.
- `lost_cnt`  out  8  saturating count of events dropped because the output register was full.
- `pileup_cnt`  out  8  saturating count of pileup-rejected pulses. Tied to 0 without the macro.
- `busy`  out  1  FSM is not IDLE.

## Operation
- Stage 1 registers `input_data` into `data_q` and the free-running counter `ts` into `ts_q`. `ts` wraps modulo 2^SIZE_PEAK_TIME.
- FSM states: IDLE, RISE, HOLDOFF.
- **IDLE:** if `data_q > thr_l`, go to RISE. `thr_l` is the live `threshold` in IDLE. On entry, latch `thr_l` = `threshold`, `max` = `data_q`, `tmax` = `ts_q`, and width counter = 1.
- **RISE:**
  - If `data_q > max`, update `max` and `tmax`. Ties keep the earlier time.
  - If `data_q <= thr_l`, the pulse ends. Emit the event, then go to HOLDOFF if `holdoff != 0`, otherwise go to IDLE.
  - `thr_l` stays frozen for the whole pulse.
- **HOLDOFF:** samples are ignored for exactly `holdoff` cycles, then the FSM returns to IDLE.
- **Emit:** if the slot is free, or `peak_valid && peak_ready` in the same cycle, load `{max, tmax}` and set `peak_valid`. Otherwise drop the event and increment `lost_cnt`.
- **Handshake:** a transfer occurs on `peak_valid && peak_ready`. `peak_valid` stays high and the data stays stable until the transfer.
- **Arithmetic:** all comparisons are signed. Counters saturate at 255 and never wrap.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `ts` = 0, stage 1 cleared.
- Reset mid-pulse or with an event pending: the event is discarded and not counted.
- The first clock edge after reset release captures a sample with `ts_q` = 0.
- Latency: a falling sample captured into `data_q` at edge k gives `peak_valid` high after edge k+1. The FSM is in HOLDOFF or IDLE from edge k+1.
- A new pulse can start at the edge after HOLDOFF ends.
- A pulse that stays above threshold indefinitely is never emitted (without the macro).
- Emit in the same cycle as a transfer: the new event replaces the old one and nothing is lost.

## Configuration
- Macro `PEAK_DET_PILEUP_EN`.
- **Defined:**
  - The width counter increments in RISE.
  - When it reaches MAX_WIDTH, the pulse is abandoned with no emit and `pileup_cnt` increments.
  - The FSM then waits in RISE-abandoned until `data_q <= thr_l`, then runs HOLDOFF as normal.
- **Undefined:** the width counter and `pileup_cnt` logic are absent, `pileup_cnt` = 0, and pulses of any length are emitted.

## Structure
- `package_settings` gains:
  - `typedef enum logic [1:0] peak_state_t {IDLE, RISE, HOLDOFF}`
  - `typedef struct packed peak_event_t {amp, time}`
  - constant `SIZE_PEAK_TIME`
- One sub-module, `peak_sat_counter`: an 8-bit saturating counter with `inc` input and async reset. It is instantiated for `lost_cnt` and `pileup_cnt`.

## Test plan
- Threshold 100, holdoff 0, `peak_ready` = 1, samples 0,50,150,300,250,90 (150 has `ts_q` = 2) → one event: `peak_amp` 300, `peak_time` 3, `peak_valid` high one cycle, 2 cycles after the 90.
- Plateau 200,400,400,50 with threshold 100 → `peak_amp` 400, `peak_time` is the first 400's timestamp.
- `peak_ready` = 0 and two pulses → first event held stable, `lost_cnt` = 1. Raising `peak_ready` in the second pulse's emit cycle → `lost_cnt` stays 0 and the second event is delivered.
- Holdoff 5, second pulse starting 3 cycles after the first ends → second pulse ignored. Starting 6 cycles after → detected.
- `PEAK_DET_PILEUP_EN`, MAX_WIDTH 8, pulse 20 cycles above threshold → no event, `pileup_cnt` 1. Without the macro → one event.
- Assert `reset` mid-pulse → all outputs 0 immediately, no event after release, `ts_q` restarts at 0.

Source files
------------

// File: rtl/pulse_peak_detector_pkg.sv
// rtl/pulse_peak_detector_pkg.sv - shared types and widths for the pulse peak detector
package pulse_peak_detector_pkg;

  localparam int SIZE_FILTER_DATA = 12;
  localparam int SIZE_PEAK_DATA   = SIZE_FILTER_DATA + 4;
  localparam int SIZE_PEAK_TIME   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISE    = 2'd1,
    HOLDOFF = 2'd2
  } peak_state_t;

  typedef struct packed {
    logic signed [SIZE_PEAK_DATA-1:0] amp;
    logic [SIZE_PEAK_TIME-1:0]        tstamp;
  } peak_event_t;

endpackage

// File: rtl/pulse_peak_detector_sat_counter.sv
// rtl/pulse_peak_detector_sat_counter.sv - 8-bit event counter that sticks at 255
module peak_sat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/pulse_peak_detector.sv
// rtl/pulse_peak_detector.sv - threshold pulse finder emitting peak amplitude/time events
// Optional pileup rejection is built when PEAK_DET_PILEUP_EN is defined.
module pulse_peak_detector #(
  parameter int SIZE_DATA      = pulse_peak_detector_pkg::SIZE_FILTER_DATA + 4,
  parameter int SIZE_PEAK_TIME = pulse_peak_detector_pkg::SIZE_PEAK_TIME,
  parameter int MAX_WIDTH      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SIZE_DATA-1:0] input_data,
  input  logic signed [SIZE_DATA-1:0] threshold,
  input  logic [7:0]                  holdoff,
  input  logic                        peak_ready,
  output logic                        peak_valid,
  output logic signed [SIZE_DATA-1:0] peak_amp,
  output logic [SIZE_PEAK_TIME-1:0]   peak_time,
  output logic [7:0]                  lost_cnt,
  output logic [7:0]                  pileup_cnt,
  output logic                        busy
);

  import pulse_peak_detector_pkg::*;

  logic signed [SIZE_DATA-1:0] data_q;
  logic [SIZE_PEAK_TIME-1:0]   ts;
  logic [SIZE_PEAK_TIME-1:0]   ts_q;

  peak_state_t                 state_q, state_d;
  logic signed [SIZE_DATA-1:0] thr_l, thr_d;
  logic signed [SIZE_DATA-1:0] max_q, max_d;
  logic [SIZE_PEAK_TIME-1:0]   tmax_q, tmax_d;
  logic [7:0]                  hold_q, hold_d;
  logic                        emit;
  logic                        slot_free;
  logic                        lost_inc;

  // Stage 1: sample and timestamp travel together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ts     <= '0;
      ts_q   <= '0;
    end else begin
      data_q <= input_data;
      ts_q   <= ts;
      ts     <= ts + 1'b1;
    end
  end

`ifdef PEAK_DET_PILEUP_EN
  localparam int WIDTH_BITS = $clog2(MAX_WIDTH + 1);

  logic [WIDTH_BITS-1:0] width_q, width_d;
  logic                  abandon_q, abandon_d;
  logic                  pileup_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q   <= '0;
      abandon_q <= 1'b0;
    end else begin
      width_q   <= width_d;
      abandon_q <= abandon_d;
    end
  end
`else
  logic [31:0] unused_max_width;
  assign unused_max_width = 32'(MAX_WIDTH);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      thr_l   <= '0;
      max_q   <= '0;
      tmax_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      thr_l   <= thr_d;
      max_q   <= max_d;
      tmax_q  <= tmax_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    thr_d   = thr_l;
    max_d   = max_q;
    tmax_d  = tmax_q;
    hold_d  = hold_q;
    emit    = 1'b0;
`ifdef PEAK_DET_PILEUP_EN
    width_d    = width_q;
    abandon_d  = abandon_q;
    pileup_inc = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (data_q > threshold) begin
          state_d = RISE;
          thr_d   = threshold;
          max_d   = data_q;
          tmax_d  = ts_q;
`ifdef PEAK_DET_PILEUP_EN
          width_d   = WIDTH_BITS'(1);
          abandon_d = 1'b0;
`endif
        end
      end
      RISE: begin
        if (data_q <= thr_l) begin
`ifdef PEAK_DET_PILEUP_EN
          emit = !abandon_q;
`else
          emit = 1'b1;
`endif
          if (holdoff != 8'd0) begin
            state_d = HOLDOFF;
            hold_d  = holdoff;
          end else begin
            state_d = IDLE;
          end
        end else begin
`ifdef PEAK_DET_PILEUP_EN
          // Once the pulse has MAX_WIDTH samples above threshold it is dropped as pileup
          if (!abandon_q) begin
            if (int'(width_q) + 1 >= MAX_WIDTH) begin
              abandon_d  = 1'b1;
              pileup_inc = 1'b1;
            end else begin
              width_d = width_q + 1'b1;
              if (data_q > max_q) begin
                max_d  = data_q;
                tmax_d = ts_q;
              end
            end
          end
`else
          if (data_q > max_q) begin
            max_d  = data_q;
            tmax_d = ts_q;
          end
`endif
        end
      end
      HOLDOFF: begin
        if (hold_q <= 8'd1) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A transfer in the emit cycle frees the slot for the new event
  assign slot_free = !peak_valid || peak_ready;
  assign lost_inc  = emit && !slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
    end else if (emit && slot_free) begin
      peak_valid <= 1'b1;
      peak_amp   <= max_q;
      peak_time  <= tmax_q;
    end else if (peak_valid && peak_ready) begin
      peak_valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  peak_sat_counter u_lost_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lost_inc),
    .count (lost_cnt)
  );

`ifdef PEAK_DET_PILEUP_EN
  peak_sat_counter u_pileup_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pileup_inc),
    .count (pileup_cnt)
  );
`else
  assign pileup_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb/tb_pulse_peak_detector.sv - directed table and sequence bench for pulse_peak_detector
module tb_pulse_peak_detector;

  import pulse_peak_detector_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] input_data = '0;
  logic signed [15:0] threshold = 16'sd100;
  logic [7:0]         holdoff = 8'd0;
  logic               peak_ready = 1'b1;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic [15:0]        peak_time;
  logic [7:0]         lost_cnt;
  logic [7:0]         pileup_cnt;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    logic signed [15:0] sample;
    logic               valid;
    logic               busy;
    peak_event_t        ev;
  } vec_t;

  vec_t tbl[17];

  pulse_peak_detector #(.MAX_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .input_data (input_data),
    .threshold  (threshold),
    .holdoff    (holdoff),
    .peak_ready (peak_ready),
    .peak_valid (peak_valid),
    .peak_amp   (peak_amp),
    .peak_time  (peak_time),
    .lost_cnt   (lost_cnt),
    .pileup_cnt (pileup_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int s, bit v, bit b, int a, int t);
    vec_t r;
    r.sample    = 16'(s);
    r.valid     = v;
    r.busy      = b;
    r.ev.amp    = 16'(a);
    r.ev.tstamp = 16'(t);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v);
    input_data = 16'(v);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    input_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    int t0;
    // rows 0-7: basic pulse, 8-13: plateau tie, 14-16: negative samples stay idle
    tbl[0]  = mk(0,    0, 0, 0,   0);
    tbl[1]  = mk(50,   0, 0, 0,   0);
    tbl[2]  = mk(150,  0, 0, 0,   0);
    tbl[3]  = mk(300,  0, 1, 0,   0);
    tbl[4]  = mk(250,  0, 1, 0,   0);
    tbl[5]  = mk(90,   0, 1, 0,   0);
    tbl[6]  = mk(0,    1, 0, 300, 3);
    tbl[7]  = mk(0,    0, 0, 0,   0);
    tbl[8]  = mk(200,  0, 0, 0,   0);
    tbl[9]  = mk(400,  0, 1, 0,   0);
    tbl[10] = mk(400,  0, 1, 0,   0);
    tbl[11] = mk(50,   0, 1, 0,   0);
    tbl[12] = mk(0,    1, 0, 400, 9);
    tbl[13] = mk(0,    0, 0, 0,   0);
    tbl[14] = mk(-200, 0, 0, 0,   0);
    tbl[15] = mk(-200, 0, 0, 0,   0);
    tbl[16] = mk(0,    0, 0, 0,   0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(peak_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_amp", 32'(peak_amp), 0);
    chk("rst_time", 32'(peak_time), 0);
    chk("rst_lost", 32'(lost_cnt), 0);
    chk("rst_pileup", 32'(pileup_cnt), 0);
    reset = 1'b0;
    edge_n = 0;

    for (int i = 0; i < 17; i++) begin
      drive(int'(tbl[i].sample));
      chk($sformatf("tbl%0d_valid", i), 32'(peak_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_amp", i), 32'(peak_amp), 32'(tbl[i].ev.amp));
        chk($sformatf("tbl%0d_time", i), 32'(peak_time), 32'(tbl[i].ev.tstamp));
      end
    end

    // Full output register: second event dropped, first held stable
    peak_ready = 1'b0;
    t0 = edge_n;
    drive(500); drive(0); drive(0);
    chk("hold_valid", 32'(peak_valid), 1);
    chk("hold_amp", 32'(peak_amp), 500);
    chk("hold_time", 32'(peak_time), 32'(t0));
    drive(600); drive(0); drive(0);
    chk("held_valid", 32'(peak_valid), 1);
    chk("held_amp", 32'(peak_amp), 500);
    chk("held_time", 32'(peak_time), 32'(t0));
    chk("lost_one", 32'(lost_cnt), 1);
    peak_ready = 1'b1;
    drive(0);
    chk("xfer_valid", 32'(peak_valid), 0);
    chk("lost_keep", 32'(lost_cnt), 1);

    // Ready raised in the emit cycle: replacement, nothing lost
    do_reset();
    peak_ready = 1'b0;
    drive(500); drive(0); drive(0);
    chk("repl_first_valid", 32'(peak_valid), 1);
    t0 = edge_n;
    drive(600); drive(0);
    peak_ready = 1'b1;
    drive(0);
    chk("repl_valid", 32'(peak_valid), 1);
    chk("repl_amp", 32'(peak_amp), 600);
    chk("repl_time", 32'(peak_time), 32'(t0));
    chk("repl_lost", 32'(lost_cnt), 0);
    drive(0);
    chk("repl_done", 32'(peak_valid), 0);

    // Holdoff 5: pulse 3 cycles after the end is ignored
    holdoff = 8'd5;
    drive(300); drive(0); drive(0);
    chk("ho_a_valid", 32'(peak_valid), 1);
    chk("ho_a_amp", 32'(peak_amp), 300);
    chk("ho_a_busy", 32'(busy), 1);
    drive(0); drive(400); drive(400); drive(0);
    chk("ho_a_busy_last", 32'(busy), 1);
    drive(0);
    chk("ho_a_idle", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0);
      chk($sformatf("ho_a_ignored%0d", i), 32'(peak_valid), 0);
    end

    // Holdoff 5: pulse 6 cycles after the end is detected
    drive(300); drive(0);
    for (int i = 0; i < 5; i++) drive(0);
    chk("ho_b_busy_last", 32'(busy), 1);
    t0 = edge_n;
    drive(400);
    chk("ho_b_idle", 32'(busy), 0);
    drive(0);
    chk("ho_b_rise", 32'(busy), 1);
    drive(0);
    chk("ho_b_valid", 32'(peak_valid), 1);
    chk("ho_b_amp", 32'(peak_amp), 400);
    chk("ho_b_time", 32'(peak_time), 32'(t0));
    holdoff = 8'd0;
    for (int i = 0; i < 7; i++) drive(0);

    // 20-cycle pulse: pileup with the feature, ordinary event without it
    t0 = edge_n;
    for (int i = 0; i < 20; i++) drive(200 + i);
    drive(0); drive(0);
`ifdef PEAK_DET_PILEUP_EN
    chk("pile_valid", 32'(peak_valid), 0);
    chk("pile_cnt", 32'(pileup_cnt), 1);
`else
    chk("long_valid", 32'(peak_valid), 1);
    chk("long_amp", 32'(peak_amp), 219);
    chk("long_time", 32'(peak_time), 32'(t0 + 19));
    chk("long_pileup", 32'(pileup_cnt), 0);
`endif
    drive(0); drive(0);

    // Reset mid-pulse clears everything at once
    drive(300); drive(300);
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(peak_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_amp", 32'(peak_amp), 0);
    chk("mid_rst_time", 32'(peak_time), 0);
    chk("mid_rst_lost", 32'(lost_cnt), 0);
    chk("mid_rst_pileup", 32'(pileup_cnt), 0);
    input_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    edge_n = 0;
    drive(300);
    chk("post_rst_v0", 32'(peak_valid), 0);
    drive(0);
    chk("post_rst_v1", 32'(peak_valid), 0);
    drive(0);
    chk("post_rst_valid", 32'(peak_valid), 1);
    chk("post_rst_amp", 32'(peak_amp), 300);
    chk("post_rst_time", 32'(peak_time), 0);
    drive(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
